// File: rtl/operand_loader.sv
// Two-press operand capture from switches into registered a/b with a valid flag.
// Optional load-button debouncer: define OPERAND_LOADER_DEBOUNCE_EN.
module operand_loader #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic         btn_load,
  input  logic         btn_clear,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         valid,
  output logic [1:0]   stage
);

  localparam logic [1:0] WAIT_A = 2'd0;
  localparam logic [1:0] WAIT_B = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic load_s1;
  logic load_s2;
  logic clear_s1;
  logic clear_s2;
  logic prev_load;
  logic load_lvl;
  logic load_p;
  logic clear_l;
  logic [1:0] state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_s1  <= 1'b0;
      load_s2  <= 1'b0;
      clear_s1 <= 1'b0;
      clear_s2 <= 1'b0;
    end else begin
      load_s1  <= btn_load;
      load_s2  <= load_s1;
      clear_s1 <= btn_clear;
      clear_s2 <= clear_s1;
    end
  end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          deb_level;

  // deb_level follows load_s2 only after it differs for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      deb_level <= 1'b0;
    end else if (load_s2 != deb_level) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_level <= ~deb_level;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign load_lvl = deb_level;
`else
  assign load_lvl = load_s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_load <= 1'b0;
    end else begin
      prev_load <= load_lvl;
    end
  end

  assign load_p  = load_lvl & ~prev_load;
  assign clear_l = clear_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      valid <= 1'b0;
      state <= WAIT_A;
    end else if (clear_l) begin
      a     <= '0;
      b     <= '0;
      valid <= 1'b0;
      state <= WAIT_A;
    end else begin
      case (state)
        WAIT_A: begin
          if (load_p) begin
            a     <= sw;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_p) begin
            b     <= sw;
            valid <= 1'b1;
            state <= READY;
          end
        end
        READY: begin
          // b is kept until the next pair overwrites it
          if (load_p) begin
            a     <= sw;
            valid <= 1'b0;
            state <= WAIT_B;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= WAIT_A;
        end
      endcase
    end
  end

  assign stage = state;

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
Upstream operand stage for the N-bit bitwise ALU operations (AND and siblings). Captures operand A, then operand B, from board switches on successive presses of a load button. Presents both operands as stable registered outputs with a valid flag. The combinational operation stage consumes a/b directly; its result is meaningful only while valid=1.

Parameters:
N, 8, operand width in bits; width of sw, a, b.
DEBOUNCE_CYCLES, 4, stable-cycle count for the load button. Used only when OPERAND_LOADER_DEBOUNCE_EN is defined; must be >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
sw  input  N  operand value from switches; must be stable around the capture edge (not synchronized).
btn_load  input  1  load button, asynchronous level.
btn_clear  input  1  clear button, asynchronous level.
a  output  N  registered operand A.
b  output  N  registered operand B.
valid  output  1  high when a and b form a complete pair.
stage  output  2  current FSM state encoding: 0 WAIT_A, 1 WAIT_B, 2 READY.

Behaviour:
- Interface decided: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async, immediate, including mid-sequence):
  - a=0, b=0, valid=0, stage=WAIT_A.
  - All synchronizer and edge flops cleared to 0.
- btn_load and btn_clear each pass through a 2-flop synchronizer (s1 -> s2).
- Load pulse: load_p = s2_load & ~prev_load, where prev_load is s2_load delayed one cycle. Exactly one pulse per rising edge; holding the button gives no repeat.
- Load latency: btn_load rises before edge 0 -> s2 high after edge 1 -> capture on edge 2; outputs update after edge 2.
- clear_l = s2_clear (level). Clear has priority over load_p in the same cycle. While clear_l=1: a=0, b=0, valid=0, stage=WAIT_A, held.
- FSM, evaluated on each edge when clear_l=0:
  - WAIT_A: on load_p, a<=sw, go to WAIT_B. Otherwise hold.
  - WAIT_B: on load_p, b<=sw, valid<=1, go to READY. Otherwise hold.
  - READY: on load_p, a<=sw, valid<=0, go to WAIT_B. b keeps its old value until it is overwritten.
  - Unused encoding 3: go to WAIT_A next edge and clear valid.
- valid is registered and changes on the same edge as the state transition.
- a and b change only on capture, clear, or reset; they are glitch-free and registered.
- A button press lasting less than 2 cycles may be missed; this is accepted.

Optional Feature:
OPERAND_LOADER_DEBOUNCE_EN
- Defined: a debouncer is inserted between s2_load and edge detection.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Each cycle s2_load != deb_level, the counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and the levels still differ, deb_level flips and the counter resets.
  - Any cycle with s2_load == deb_level resets the counter.
  - load_p is derived from deb_level rising. Capture occurs on edge 2+DEBOUNCE_CYCLES (edge 6 at default).
  - Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
  - The clear path is not debounced.
  - Reset clears the counter and deb_level.
- Undefined: no counter logic; behaviour and latency exactly as in Behaviour.

Test Plan:
- Reset check: rst=1 mid-WAIT_B with a=0x96 -> same cycle a=0, b=0, valid=0, stage=0.
- Full load: sw=0x96, pulse btn_load (3 cycles); then sw=0xAA, pulse again.
  - First press: a=0x96 on edge 2 after the press, stage=1.
  - Second press: b=0xAA, valid=1, stage=2. The downstream AND reads 0x82.
- Hold: btn_load held high 20 cycles in WAIT_A with sw=0x11 -> exactly one capture, a=0x11, stage=1; no further change.
- Reload from READY: in READY with a=0x96, b=0xAA, sw=0x0F, press -> a=0x0F, b=0xAA, valid=0, stage=1.
- Clear priority: in READY, assert btn_clear and btn_load together -> a=0, b=0, valid=0, stage=0 and no capture.
- Debounce (macro defined, DEBOUNCE_CYCLES=4):
  - 2-cycle glitches on btn_load -> no capture.
  - Clean press with sw=0x3C -> a=0x3C on edge 6 after the rise.
  - Same test with the macro undefined -> capture on edge 2.
